// File: rtl/shared_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shared_pkg
// Description : Shared sizing defaults, flag bit positions and counter type
//               for the FIFO scoreboard and its golden reference model.
// Revision    : 1.0 - initial release
// ============================================================================
package shared_pkg;

  // Default data width and storage depth (depth must be a power of two)
  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 8;

  // Bit positions inside the 7-bit flag vector {wr_ack .. almostempty}
  localparam int FLAG_WR_ACK      = 6;
  localparam int FLAG_OVERFLOW    = 5;
  localparam int FLAG_UNDERFLOW   = 4;
  localparam int FLAG_FULL        = 3;
  localparam int FLAG_EMPTY       = 2;
  localparam int FLAG_ALMOSTFULL  = 1;
  localparam int FLAG_ALMOSTEMPTY = 0;
  localparam int NUM_FLAGS        = 7;

  // Position of the data-out failure bit inside mismatch_vec
  localparam int VEC_DATA_BIT = 7;

  // Cumulative comparison counter type and its saturation value
  typedef logic [15:0] cnt16_t;
  localparam cnt16_t CNT_MAX = 16'hFFFF;

  // Saturating increment used by both result counters
  function automatic cnt16_t sat_inc(input cnt16_t value);
    return (value == CNT_MAX) ? CNT_MAX : value + 16'd1;
  endfunction

endpackage : shared_pkg
`default_nettype wire

// File: rtl/fifo_ref_model.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ref_model
// Description : Golden synchronous FIFO. Registered data_out, wr_ack,
//               overflow and underflow; full/empty/almost flags decoded
//               combinationally from the occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ref_model #(
  parameter int FIFO_WIDTH = shared_pkg::FIFO_WIDTH,
  parameter int FIFO_DEPTH = shared_pkg::FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic [6:0]            flags
);
  import shared_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] C_AFULL  = CW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [CW-1:0] C_ZERO   = '0;

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  wr_ok;
  logic                  rd_ok;

  // Accept decisions: a full FIFO refuses writes, an empty one refuses reads,
  // which also resolves the simultaneous request corner cases.
  assign wr_ok = wr_en && (count != C_DEPTH);
  assign rd_ok = rd_en && (count != C_ZERO);

  // Storage array is deliberately not reset; only pointers define validity
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy, read data and per-cycle event flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_ok;
      overflow  <= wr_en && !wr_ok;
      underflow <= rd_en && !rd_ok;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: count <= count;
      endcase
    end
  end

  // Assemble the flag vector; level flags come straight from count
  always_comb begin
    flags                   = '0;
    flags[FLAG_WR_ACK]      = wr_ack;
    flags[FLAG_OVERFLOW]    = overflow;
    flags[FLAG_UNDERFLOW]   = underflow;
    flags[FLAG_FULL]        = (count == C_DEPTH);
    flags[FLAG_EMPTY]       = (count == C_ZERO);
    flags[FLAG_ALMOSTFULL]  = (count == C_AFULL);
    flags[FLAG_ALMOSTEMPTY] = (count == C_ONE);
  end

endmodule : fifo_ref_model
`default_nettype wire

// File: rtl/fifo_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : fifo_scoreboard
// Description : Compares an observed FIFO's read data and flags against the
//               golden reference model every cycle, reporting per-field
//               failures and keeping saturating pass/fail totals.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_scoreboard #(
  parameter int FIFO_WIDTH = shared_pkg::FIFO_WIDTH,
  parameter int FIFO_DEPTH = shared_pkg::FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] dut_data_out,
  input  logic [6:0]            dut_flags,
  output logic                  mismatch,
  output logic [7:0]            mismatch_vec,
  output logic [15:0]           error_count,
  output logic [15:0]           correct_count
);
  import shared_pkg::*;

  logic [FIFO_WIDTH-1:0] model_data;
  logic [6:0]            model_flags;
  logic                  cmp_en;
  logic [7:0]            diff;

  fifo_ref_model #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_ref (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_out (model_data),
    .flags    (model_flags)
  );

  // Field-by-field difference, forced clean while comparisons are disarmed
  always_comb begin
    diff = '0;
    if (cmp_en) begin
      diff[VEC_DATA_BIT]    = (dut_data_out != model_data);
      diff[NUM_FLAGS-1:0]   = dut_flags ^ model_flags;
    end
  end

  // Arm after the first post-reset edge, register results, bump one counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_en        <= 1'b0;
      mismatch      <= 1'b0;
      mismatch_vec  <= '0;
      error_count   <= '0;
      correct_count <= '0;
    end else begin
      cmp_en       <= 1'b1;
      mismatch_vec <= diff;
      mismatch     <= |diff;
      if (cmp_en) begin
        if (|diff) begin
          error_count <= sat_inc(error_count);
        end else begin
          correct_count <= sat_inc(correct_count);
        end
      end
    end
  end

endmodule : fifo_scoreboard
`default_nettype wire

// File: tb/tb_fifo_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_scoreboard
// Description : Directed bench. The bench plays the FIFO under check by
//               presenting hand-computed read data and flags each cycle and
//               checks the scoreboard's verdicts and counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] dut_data_out;
  logic [6:0]  dut_flags;
  logic        mismatch;
  logic [7:0]  mismatch_vec;
  logic [15:0] error_count;
  logic [15:0] correct_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_ok = 0;
  int exp_bad = 0;

  fifo_scoreboard u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_in       (data_in),
    .wr_en         (wr_en),
    .rd_en         (rd_en),
    .dut_data_out  (dut_data_out),
    .dut_flags     (dut_flags),
    .mismatch      (mismatch),
    .mismatch_vec  (mismatch_vec),
    .error_count   (error_count),
    .correct_count (correct_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag vector {wr_ack, overflow, underflow, full, empty, afull, aempty}
  function automatic logic [6:0] fl(input logic a, input logic o, input logic u, input int c);
    return {a, o, u, (c == 8), (c == 0), (c == 7), (c == 1)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive request + the FIFO-under-check view of the model state
  // going into this edge, then check the verdict registered at the edge.
  task automatic cyc(input logic wr, input logic rd, input logic [15:0] din,
                     input logic [15:0] edout, input logic [6:0] ef,
                     input logic [7:0] ev, input bit cmp);
    wr_en        = wr;
    rd_en        = rd;
    data_in      = din;
    dut_data_out = edout;
    dut_flags    = ef;
    if (cmp) begin
      if (ev != 8'h00) exp_bad++;
      else             exp_ok++;
    end
    @(posedge clk);
    #1;
    chk("mismatch_vec", {24'h0, mismatch_vec}, {24'h0, ev});
    chk("mismatch", {31'h0, mismatch}, {31'h0, (ev != 8'h00)});
    chk("error_count", {16'h0, error_count}, exp_bad);
    chk("correct_count", {16'h0, correct_count}, exp_ok);
    @(negedge clk);
  endtask

  task automatic reset_checks();
    chk("rst_mismatch", {31'h0, mismatch}, 32'h0);
    chk("rst_vec", {24'h0, mismatch_vec}, 32'h0);
    chk("rst_err", {16'h0, error_count}, 32'h0);
    chk("rst_ok", {16'h0, correct_count}, 32'h0);
  endtask

  initial begin
    rst_n        = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    data_in      = '0;
    dut_data_out = '0;
    dut_flags    = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset: garbage observed values must not be compared
    cyc(1'b0, 1'b0, 16'h0, 16'hBEEF, 7'h7F, 8'h00, 1'b0);

    // Fill with 1..8, then one write too many
    for (int i = 1; i <= 8; i++)
      cyc(1'b1, 1'b0, 16'(i), 16'h0, (i == 1) ? fl(0, 0, 0, 0) : fl(1, 0, 0, i - 1), 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 16'h0009, 16'h0, fl(1, 0, 0, 8), 8'h00, 1'b1);

    // Drain 8 in order, then one read too many
    for (int j = 1; j <= 8; j++)
      cyc(1'b0, 1'b1, 16'h0, 16'(j - 1), (j == 1) ? fl(0, 1, 0, 8) : fl(0, 0, 0, 9 - j), 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 16'h0, 16'h0008, fl(0, 0, 0, 0), 8'h00, 1'b1);

    // Simultaneous at empty: write only plus underflow; then fill to 8
    cyc(1'b1, 1'b1, 16'h00A1, 16'h0008, fl(0, 0, 1, 0), 8'h00, 1'b1);
    for (int k = 2; k <= 8; k++)
      cyc(1'b1, 1'b0, 16'(16'h00A0 + k), 16'h0008, (k == 2) ? fl(1, 0, 1, 1) : fl(1, 0, 0, k - 1), 8'h00, 1'b1);

    // Simultaneous at full: read only plus overflow; then two reads to count 5
    cyc(1'b1, 1'b1, 16'h00B0, 16'h0008, fl(1, 0, 0, 8), 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 16'h0, 16'h00A1, fl(0, 1, 0, 7), 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 16'h0, 16'h00A2, fl(0, 0, 0, 6), 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 16'h0, 16'h00A3, fl(0, 0, 0, 5), 8'h00, 1'b1);

    // Asynchronous reset mid-operation at count 5
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks();
    exp_ok  = 0;
    exp_bad = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 16'h0, 16'hBEEF, 7'h7F, 8'h00, 1'b0);

    // Restart empty, then 12 writes through simultaneous traffic across the wrap
    cyc(1'b1, 1'b0, 16'h00C0, 16'h0, fl(0, 0, 0, 0), 8'h00, 1'b1);
    for (int k = 1; k <= 11; k++)
      cyc(1'b1, 1'b1, 16'(16'h00C0 + k), (k == 1) ? 16'h0 : 16'(16'h00C0 + k - 2),
          fl(1, 0, 0, 1), 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 16'h0, 16'h00CA, fl(1, 0, 0, 1), 8'h00, 1'b1);

    // Load 1..3, read them back, then corrupt the observed data of the third
    cyc(1'b1, 1'b0, 16'h0001, 16'h00CB, fl(0, 0, 0, 0), 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 16'h0002, 16'h00CB, fl(1, 0, 0, 1), 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 16'h0003, 16'h00CB, fl(1, 0, 0, 2), 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 16'h0, 16'h00CB, fl(1, 0, 0, 3), 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 16'h0, 16'h0001, fl(0, 0, 0, 2), 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 16'h0, 16'h0002, fl(0, 0, 0, 1), 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 16'h0, 16'hDEAD, fl(0, 0, 0, 0), 8'h80, 1'b1);
    cyc(1'b0, 1'b0, 16'h0, 16'h0003, fl(0, 0, 0, 0), 8'h00, 1'b1);
    // Observed empty flag wrongly low while the model is empty
    cyc(1'b0, 1'b0, 16'h0, 16'h0003, 7'h00, 8'h04, 1'b1);
    cyc(1'b0, 1'b0, 16'h0, 16'h0003, fl(0, 0, 0, 0), 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fifo_scoreboard
`default_nettype wire
